// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - selection mode constants and width helper for the stream mux
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Fallback for flows without $clog2; returns at least 1 so index ports never collapse.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - per-channel input streams and registered output stream
interface stream_mux_rr_if #(
  parameter int NUM_CH = 16,
  parameter int WIDTH  = 20
);
  localparam int ADDR_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [ADDR_W-1:0]       out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first requester after ptr
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 16,
  localparam int ADDR_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              grant_valid,
  output logic [ADDR_W-1:0] grant_idx
);

  int                sum;
  logic [ADDR_W-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    cand        = '0;
    // Walk from the farthest candidate back to ptr+1 so the nearest requester is assigned last.
    for (int i = NUM_CH; i >= 1; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_CH) begin
        sum = sum - NUM_CH;
      end
      cand = ADDR_W'(sum);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream mux with fixed-address or round-robin select
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 16,
  parameter  int WIDTH  = 20,
  localparam int ADDR_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  stream_mux_rr_if.slave    bus
);

  logic [WIDTH-1:0]  ch_data [NUM_CH];
  logic [ADDR_W-1:0] rr_ptr;
  logic [ADDR_W-1:0] rr_idx;
  logic              rr_valid;
  logic [ADDR_W-1:0] grant_idx;
  logic              grant_ok;
  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] in_ready;
  logic [WIDTH-1:0]  out_data_q;
  logic [ADDR_W-1:0] out_ch_q;
  logic              out_valid_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req         (bus.in_valid),
    .ptr         (rr_ptr),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // Fixed mode grants addr whether or not it is valid; out-of-range addr grants nothing.
  always_comb begin
    grant_idx = addr;
    grant_ok  = (int'(addr) < NUM_CH);
    if (mode == MODE_RR) begin
      grant_idx = rr_idx;
      grant_ok  = rr_valid;
    end
  end

  // No handshake is offered while reset is held.
  assign load_en = rst_n && (!out_valid_q || bus.out_ready);
  assign xfer    = grant_ok && load_en && bus.in_valid[grant_idx];

  always_comb begin
    in_ready = '0;
    if (grant_ok && load_en) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= ADDR_W'(NUM_CH - 1);
    end else if (load_en) begin
      if (xfer) begin
        out_data_q  <= ch_data[grant_idx];
        out_ch_q    <= grant_idx;
        out_valid_q <= 1'b1;
        if (mode == MODE_RR) begin
          rr_ptr <= grant_idx;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed bench with a cycle model of the registered stream mux
module tb_stream_mux_rr;

  localparam int NCH = 16;
  localparam int W   = 20;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] addr  = 4'd0;

  int tests = 0;
  int fails = 0;

  logic          m_valid = 1'b0;
  logic [W-1:0]  m_data  = '0;
  int            m_ch    = 0;
  int            m_ptr   = NCH - 1;

  stream_mux_rr_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

  stream_mux_rr #(
    .NUM_CH (NCH),
    .WIDTH  (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .addr  (addr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Channel chosen by the selection rules, or -1 when nothing may be granted.
  function automatic int model_grant(input logic m, input logic [3:0] a,
                                     input logic [NCH-1:0] v, input int ptr);
    if (m == 1'b0) return (int'(a) < NCH) ? int'(a) : -1;
    for (int i = 1; i <= NCH; i++) begin
      if (v[(ptr + i) % NCH]) return (ptr + i) % NCH;
    end
    return -1;
  endfunction

  initial begin : model_proc
    int g;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = NCH - 1;
      end else if (!m_valid || bus.out_ready) begin
        g = model_grant(mode, addr, bus.in_valid, m_ptr);
        if (g >= 0 && bus.in_valid[g]) begin
          m_data  = bus.in_data[g*W +: W];
          m_ch    = g;
          m_valid = 1'b1;
          if (mode) m_ptr = g;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin : compare_proc
    int g;
    logic [NCH-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);
        check("reset_out_ch", 32'(bus.out_ch), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
      end else begin
        g = model_grant(mode, addr, bus.in_valid, m_ptr);
        exp_rdy = '0;
        if (g >= 0 && (!m_valid || bus.out_ready)) exp_rdy[g] = 1'b1;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
          check("out_data", 32'(bus.out_data), 32'(m_data));
          check("out_ch", 32'(bus.out_ch), 32'(m_ch));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_word(input string name, input int ch);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_ch"}, 32'(bus.out_ch), 32'(ch));
    check({name, "_data"}, 32'(bus.out_data), 32'h000A0000 + 32'(ch));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int seq3 [5];
    logic [4:0] rdy_pat [12];
    seq3 = '{2, 7, 15, 2, 7};
    rdy_pat = '{5'd1, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd1, 5'd1};

    for (int k = 0; k < NCH; k++) bus.in_data[k*W +: W] = 20'hA0000 + W'(k);
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    mode = 1'b0;
    addr = 4'd5;

    // 1: reset state, then a single fixed transfer from channel 5
    repeat (2) cyc();
    check("t1_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t1_rst_data", 32'(bus.out_data), 32'd0);
    check("t1_rst_ready", 32'(bus.in_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 16'h0020;
    cyc();
    expect_word("t1_word", 5);
    #1 bus.in_valid = '0;
    cyc();
    check("t1_one_cycle", 32'(bus.out_valid), 32'd0);

    // 2: fixed mode ignores other valid channels
    #1;
    addr = 4'd3;
    bus.in_valid = '1;
    #1 check("t2_ready", 32'(bus.in_ready), 32'h0008);
    for (int i = 0; i < 4; i++) begin
      cyc();
      expect_word("t2_word", 3);
      check("t2_ready_only3", 32'(bus.in_ready), 32'h0008);
    end

    // 3: round-robin across channels 2, 7, 15
    #1;
    mode = 1'b1;
    bus.in_valid = 16'h8084;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_word("t3_rr", seq3[i]);
    end

    // 4: wrap-around after a grant to 14
    #1 bus.in_valid = 16'h4000;
    cyc();
    expect_word("t4_g14", 14);
    #1 bus.in_valid = 16'h4001;
    cyc();
    expect_word("t4_wrap0", 0);
    cyc();
    expect_word("t4_then14", 14);

    // 5: back-pressure holding A0007, then no-bubble reload
    #1;
    mode = 1'b0;
    addr = 4'd7;
    bus.in_valid = 16'h0080;
    cyc();
    expect_word("t5_load", 7);
    #1;
    bus.out_ready = 1'b0;
    addr = 4'd1;
    bus.in_valid = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_word("t5_stall", 7);
      check("t5_stall_ready", 32'(bus.in_ready), 32'd0);
    end
    #1 bus.out_ready = 1'b1;
    #1 check("t5_release_ready", 32'(bus.in_ready), 32'h0002);
    cyc();
    expect_word("t5_nobubble", 1);

    // 6: park rr pointer on 0, stall, then reset between edges
    #1;
    mode = 1'b1;
    bus.in_valid = 16'h0001;
    cyc();
    expect_word("t6_pre", 0);
    #1 bus.out_ready = 1'b0;
    cyc();
    expect_word("t6_held", 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check("t6_async_data", 32'(bus.out_data), 32'd0);
    cyc();
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 16'h0003;
    cyc();
    expect_word("t6_first", 0);
    cyc();
    expect_word("t6_second", 1);

    // 7: all channels valid with intermittent back-pressure, checked by the model
    #1 bus.in_valid = '1;
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = rdy_pat[i][0];
      cyc();
      #1;
    end
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit registered stream multiplexor with valid/ready handshakes on every input and on the output.
- Two selection modes: fixed-address, where the channel is picked by `addr` as in the combinational 16x20 multiplexor, and round-robin arbitration across all valid channels.
- One output register stage.
- Feeds the CPU's shared result/writeback bus from multiple producers.

Parameters:
- NUM_CH, 16, number of input channels (2..64).
- WIDTH, 20, data width per channel in bits.
- ADDR_W, $clog2(NUM_CH), channel index width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- mode  in  1  0 = fixed-address, 1 = round-robin.
- addr  in  ADDR_W  selected channel in fixed mode; ignored in round-robin.
- out_data  out  WIDTH  registered data.
- out_ch  out  ADDR_W  source channel index of out_data.
- out_valid  out  1  output holds a word.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset (async assert, sync release) sets:
  - out_valid=0, out_data=0, out_ch=0.
  - rr_ptr (last granted channel) = NUM_CH-1, so channel 0 has highest priority after reset.
- Output register:
  - load_en = !out_valid || out_ready.
  - Transfer from channel g occurs when in_valid[g] && in_ready[g].
- Grant and in_ready:
  - Combinational from the current inputs and state.
  - in_ready[g]=1 only for the granted channel, and only when load_en.
- Fixed mode:
  - g = addr.
  - Channels other than addr never see ready.
  - addr >= NUM_CH (non-power-of-2 NUM_CH): no grant; all in_ready=0.
- Round-robin mode:
  - g = first k with in_valid[k], searching from rr_ptr+1 upward and wrapping modulo NUM_CH.
  - No valid input: no grant.
  - rr_ptr <= g only on a transfer.
- Register update on a clock edge with load_en:
  - Transfer: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - No transfer and out_ready: out_valid <= 0. out_data and out_ch hold their old values.
- Stall (out_valid && !out_ready):
  - out_data and out_ch are stable.
  - All in_ready=0.
- Latency and throughput:
  - Latency 1 cycle from input transfer to out_valid.
  - Full throughput of 1 word/cycle with out_ready held high.
- Simultaneous consume and load: the new word replaces the old one in the same edge, with no bubble.
- Mode or addr change:
  - Takes effect on the next grant evaluation.
  - A word already in the output register is unaffected.
  - rr_ptr persists across fixed-mode periods; fixed-mode transfers do not update it.
- Reset mid-operation:
  - Any held output word is discarded immediately (out_valid drops asynchronously).
  - rr_ptr returns to NUM_CH-1.
- Inputs must hold data stable while valid and not ready. The block does not check this.

Decomposition:
- Shared package `stream_mux_pkg`:
  - Mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Function clog2 if the toolchain lacks $clog2.
- Sub-module `rr_arbiter`:
  - Parameter NUM_CH.
  - Inputs: req[NUM_CH], ptr[ADDR_W].
  - Outputs: grant_valid, grant_idx.
  - Purely combinational rotate/priority-encode. Reusable by other shared-bus blocks.
- Top level: owns the output register, rr_ptr, mode mux and ready generation.

Test Plan (NUM_CH=16, WIDTH=20, channel k data = 20'hA0000+k unless stated):
1. Reset state, then a single fixed transfer:
   - During reset: out_valid=0, out_data=0, in_ready=0.
   - After release: mode=0, addr=5, only in_valid[5]=1, out_ready=1.
   - Required: next cycle out_data=20'hA0005, out_ch=5, out_valid=1 for exactly one cycle.
2. Fixed mode ignores other channels:
   - Stimulus: all in_valid=1, addr=3, 4 cycles, out_ready=1.
   - Required: four words 20'hA0003 with out_ch=3; in_ready[3] the only ready bit.
3. Round-robin fairness:
   - Stimulus: mode=1, in_valid on channels 2, 7, 15 held, out_ready=1.
   - Required: out_ch sequence 2, 7, 15, 2, 7 with back-to-back valid (no bubbles).
4. Wrap-around and pointer:
   - Stimulus: mode=1, after a grant to 14, only channels 0 and 14 valid.
   - Required: next grants 0, then 14.
5. Back-pressure:
   - Stimulus: out_ready=0 for 3 cycles with a word 20'hA0007 held.
   - Required: out_data, out_ch and out_valid stable; all in_ready=0.
   - Then out_ready=1: next word loads in the same cycle with no bubble.
6. Reset mid-stall:
   - Stimulus: assert rst_n=0 asynchronously between edges while out_valid=1.
   - Required: out_valid=0 immediately.
   - After release, mode=1 with channels 0 and 1 valid: first grant is channel 0.
